// File: rtl/calc_input_parser.sv
// calc_input_parser: ASCII front-end for the calculator. Accumulates two
// unsigned decimal operands from a byte stream and emits the strobes the
// operator interpreter consumes (got_dig, load_cmd + data, rdy).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for the first digit of a new expression
// S_A    | accumulating operand A
// S_OP   | operator accepted, waiting for the first digit of B
// S_B    | accumulating operand B, waiting for '=' or CR
// S_ERR  | malformed expression or overflow, held until ESC
module calc_input_parser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic [7:0]       data,
    output logic             load_cmd,
    output logic             got_dig,
    output logic             rdy,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_OP,
        S_B,
        S_ERR
    } state_t;

    localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

    state_t           state;
    logic             is_digit;
    logic             is_op;
    logic             is_eq;
    logic             is_esc;
    logic [3:0]       digit_val;
    logic [WIDTH-1:0] digit_ext;
    logic [WIDTH+3:0] acc_a;
    logic [WIDTH+3:0] acc_b;
    logic             ovf_a;
    logic             ovf_b;

    // Classify the incoming byte and precompute the widened accumulations;
    // the extra four bits catch any result above 2^WIDTH-1.
    always_comb begin
        is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_op     = (rx_data == 8'h2A) || (rx_data == 8'h2B) ||
                    (rx_data == 8'h2D) || (rx_data == 8'h2F);
        is_eq     = (rx_data == 8'h3D) || (rx_data == 8'h0D);
        is_esc    = (rx_data == 8'h1B);
        digit_val = rx_data[3:0];
        digit_ext = WIDTH'(digit_val);
        acc_a     = {4'd0, op_a} * TEN + {{WIDTH{1'b0}}, digit_val};
        acc_b     = {4'd0, op_b} * TEN + {{WIDTH{1'b0}}, digit_val};
        ovf_a     = (acc_a[WIDTH+3:WIDTH] != 4'd0);
        ovf_b     = (acc_b[WIDTH+3:WIDTH] != 4'd0);
    end

    // Parser FSM with registered operands, strobes and status levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            data     <= 8'd0;
            load_cmd <= 1'b0;
            got_dig  <= 1'b0;
            rdy      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            load_cmd <= 1'b0;
            got_dig  <= 1'b0;
            rdy      <= 1'b0;
            if (rx_valid) begin
                if (is_esc) begin
                    state <= S_IDLE;
                    op_a  <= '0;
                    op_b  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (is_digit) begin
                                op_a    <= digit_ext;
                                op_b    <= '0;
                                got_dig <= 1'b1;
                                busy    <= 1'b1;
                                state   <= S_A;
                            end else if (is_op || is_eq) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_ERR;
                            end
                        end
                        S_A: begin
                            if (is_digit) begin
                                if (ovf_a) begin
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_ERR;
                                end else begin
                                    op_a <= acc_a[WIDTH-1:0];
                                end
                            end else if (is_op) begin
                                data     <= rx_data;
                                load_cmd <= 1'b1;
                                state    <= S_OP;
                            end else if (is_eq) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_ERR;
                            end
                        end
                        S_OP: begin
                            if (is_digit) begin
                                op_b  <= digit_ext;
                                state <= S_B;
                            end else if (is_op) begin
                                // A later operator simply replaces the earlier one.
                                data     <= rx_data;
                                load_cmd <= 1'b1;
                            end else if (is_eq) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_ERR;
                            end
                        end
                        S_B: begin
                            if (is_digit) begin
                                if (ovf_b) begin
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_ERR;
                                end else begin
                                    op_b <= acc_b[WIDTH-1:0];
                                end
                            end else if (is_eq) begin
                                rdy   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else if (is_op) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_ERR;
                            end
                        end
                        S_ERR: begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end
                        default: begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERR;
                        end
                    endcase
                end
            end
        end
    end

endmodule
